mfp_timer_bank: RTL
===================

# mfp_timer_bank

Multi-channel programmable timer for the MIPSfpga AHB-Lite peripheral set. It replaces the single fixed-interval `timer_count` and runs on the 50 MHz system clock. Each of N_CH channels has a programmable period, one-shot or periodic mode, and sticky expiry and overrun flags that the CPU clears by acknowledging. All channels share one prescaler, so long intervals are possible without a wide per-channel counter.

## Interface
Parameters:
- N_CH, 4: number of timer channels, 1..16.
- CNT_W, 32: width of the period and down-counter, 8..32.
- PS_W, 8: width of the shared prescaler.

Ports:
- clk  in  1  system clock (50 MHz domain). One clock; reset is asynchronous and active-low.
- resetn  in  1  asynchronous active-low reset.
- prescale  in  PS_W  tick divisor: one tick every prescale+1 clocks; quasi-static.
- cfg_we  in  1  single-cycle configuration write strobe.
- cfg_ch  in  $clog2(N_CH) (min 1)  channel addressed by cfg_we.
- cfg_period  in  CNT_W  period in ticks; 0 means stop the channel.
- cfg_periodic  in  1  1 = auto-reload; 0 = one-shot.
- ack  in  N_CH  per-channel clear strobes for time_is_up and overrun.
- rd_ch  in  $clog2(N_CH)  channel whose live count is returned.
- rd_count  out  CNT_W  live counter of rd_ch, combinational mux.
- running  out  N_CH  channel is in RUN.
- time_is_up  out  N_CH  sticky expiry flag.
- overrun  out  N_CH  sticky flag: an expiry occurred while time_is_up was still set.

## Operation
- Prescaler:
  - Free-running counter ps_cnt.
  - When ps_cnt == prescale, assert tick for one cycle and set ps_cnt to 0; otherwise increment.
  - If prescale is lowered below ps_cnt, the next cycle wraps to 0 with no tick (ps_cnt >= prescale wraps).
- Channel states: IDLE, RUN, DONE.
- cfg_we to channel c, with any state:
  - Load count := cfg_period and latch period and mode.
  - Clear time_is_up[c] and overrun[c].
  - Go to RUN if cfg_period != 0, else IDLE.
- RUN, on tick:
  - If count > 1: decrement.
  - If count == 1 (expiry): set time_is_up.
    - Periodic: count := period, stay in RUN.
    - One-shot: count := 0, go to DONE.
- IDLE and DONE: the counter holds and ticks are ignored. Leave only via cfg_we.
- Overrun:
  - An expiry while time_is_up is already 1 and ack is 0 sets overrun; time_is_up stays 1.
- Simultaneous ack and expiry on the same channel:
  - time_is_up ends at 1 (new event retained).
  - overrun ends at 0 (old event consumed).
- Simultaneous cfg_we and ack on the same channel: cfg_we wins; both flags end at 0.
- Simultaneous cfg_we and expiry on the same channel: cfg_we wins; no flag is set.
- ack on a channel with time_is_up = 0 has no effect.
- cfg_we with cfg_ch >= N_CH is ignored.
- Arithmetic: counters are unsigned CNT_W. Reload never overflows because period <= 2^CNT_W-1.

## Timing
- Reset values (asynchronous, immediate):
  - ps_cnt = 0, every count = 0, every period = 0, every state IDLE.
  - running = 0, time_is_up = 0, overrun = 0.
  - rd_count = 0.
- All flags are registered outputs.
- cfg_we, ack and tick are sampled at the same rising edge.
- With prescale = 0, a write of period P at edge k:
  - count = P after edge k;
  - time_is_up rises after edge k+P;
  - periodic expiries then recur every P clocks.
- With prescale = S:
  - Periodic expiries are spaced exactly P*(S+1) clocks apart.
  - First-expiry latency after a write lies in [(P-1)(S+1)+1, P(S+1)] clocks.
- ack clears the flags at the next edge; there is no further latency.
- Reset asserted mid-count aborts everything. After release, channels stay IDLE until reprogrammed.

## Structure
- Package mfp_timer_pkg:
  - state enum (IDLE/RUN/DONE);
  - mode constants MODE_ONESHOT = 1'b0, MODE_PERIODIC = 1'b1.
- Sub-module mfp_timer_channel, instantiated N_CH times via generate. Ports:
  - inputs clk, resetn, tick, load, load_period, load_periodic, ack;
  - outputs count, running, time_is_up, overrun.
- Top level holds the prescaler, the cfg_ch decode and the rd_ch mux.

## Test plan
- Reset/idle: resetn low, then high, with prescale = 0 and no writes for 100 clocks. All outputs stay 0.
- One-shot latency: prescale = 0, write ch0 P = 5 one-shot.
  - time_is_up[0] rises exactly 5 clocks after the write.
  - rd_count reads 0 and running[0] = 0 afterwards.
  - No second expiry within 50 clocks.
- Periodic spacing: prescale = 4, write ch2 P = 3 periodic, ack each expiry.
  - Successive rises of time_is_up[2] are 15 clocks apart over 10 periods.
- Overrun and simultaneous events, ch1 P = 2 periodic, prescale = 0:
  - No ack: overrun[1] = 1 after the second expiry.
  - ack on the expiry cycle: time_is_up = 1 and overrun = 0.
- Reconfigure mid-run: ch3 running P = 100. At count 40, write P = 0.
  - running[3] = 0 and flags cleared.
  - Then write P = 7: expiry 7 clocks later.
  - Other channels' timing is unaffected throughout.
- Reset mid-operation: resetn pulsed low for 1 clock while all 4 channels run. All outputs return to 0 immediately and remain 0.

Source files
------------

// File: rtl/mfp_timer_pkg.sv
// Shared types for the multi-channel timer bank: channel state encoding and
// the one-shot / periodic mode constants.
package mfp_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/mfp_timer_channel.sv
// One timer channel: down-counter with reload, IDLE/RUN/DONE state and
// sticky expiry/overrun flags cleared by ack or by reprogramming.
module mfp_timer_channel
  import mfp_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_period,
  input  logic             load_periodic,
  input  logic             ack,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             time_is_up,
  output logic             overrun
);

  ch_state_t        state, state_n;
  logic [CNT_W-1:0] period, period_n, count_n;
  logic             periodic, periodic_n;
  logic             tiu_n, ovr_n;
  logic             expire;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      count      <= '0;
      period     <= '0;
      periodic   <= MODE_ONESHOT;
      time_is_up <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      period     <= period_n;
      periodic   <= periodic_n;
      time_is_up <= tiu_n;
      overrun    <= ovr_n;
    end
  end

  // A load overrides everything else in the same cycle, including an expiry or ack.
  always_comb begin
    state_n    = state;
    count_n    = count;
    period_n   = period;
    periodic_n = periodic;
    tiu_n      = time_is_up;
    ovr_n      = overrun;
    expire     = 1'b0;
    if (load) begin
      count_n    = load_period;
      period_n   = load_period;
      periodic_n = load_periodic;
      state_n    = (load_period != '0) ? ST_RUN : ST_IDLE;
      tiu_n      = 1'b0;
      ovr_n      = 1'b0;
    end else begin
      if (state == ST_RUN && tick) begin
        if (count > CNT_W'(1)) begin
          count_n = count - CNT_W'(1);
        end else begin
          expire = 1'b1;
          if (periodic == MODE_PERIODIC) begin
            count_n = period;
          end else begin
            count_n = '0;
            state_n = ST_DONE;
          end
        end
      end
      // An ack coinciding with an expiry consumes the old event but keeps the new one.
      if (expire) begin
        tiu_n = 1'b1;
        ovr_n = time_is_up & ~ack;
      end else if (ack) begin
        tiu_n = 1'b0;
        ovr_n = 1'b0;
      end
    end
  end

  assign running = (state == ST_RUN);

endmodule

// File: rtl/mfp_timer_bank.sv
// Multi-channel programmable timer: shared prescaler, channel write decode
// and a combinational read mux for the live count of one channel.
module mfp_timer_bank
  import mfp_timer_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32,
  parameter int PS_W  = 8,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [PS_W-1:0]  prescale,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_periodic,
  input  logic [N_CH-1:0]  ack,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [CNT_W-1:0] rd_count,
  output logic [N_CH-1:0]  running,
  output logic [N_CH-1:0]  time_is_up,
  output logic [N_CH-1:0]  overrun
);

  logic [PS_W-1:0]  ps_cnt;
  logic             tick;
  logic [N_CH-1:0]  load_ch;
  logic [CNT_W-1:0] counts [N_CH];

  assign tick = (ps_cnt == prescale);

  // The >= compare lets a lowered prescale wrap immediately instead of counting to overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ps_cnt <= '0;
    end else if (ps_cnt >= prescale) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : ch_gen
    assign load_ch[g] = cfg_we && (int'(cfg_ch) == g);

    mfp_timer_channel #(
      .CNT_W(CNT_W)
    ) u_channel (
      .clk          (clk),
      .resetn       (resetn),
      .tick         (tick),
      .load         (load_ch[g]),
      .load_period  (cfg_period),
      .load_periodic(cfg_periodic),
      .ack          (ack[g]),
      .count        (counts[g]),
      .running      (running[g]),
      .time_is_up   (time_is_up[g]),
      .overrun      (overrun[g])
    );
  end

  always_comb begin
    rd_count = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(rd_ch) == i) rd_count = counts[i];
    end
  end

endmodule
